// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the Mini-MIPS datapath: owns PC/IR, steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives RF, ALU and DMEM controls.
module mips_multicycle_ctrl #(
  parameter int          PC_W      = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     imem_data,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  output logic [4:0]      rf_wa,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic            dmem_we,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BR, C_J, C_JR, C_JAL} cls_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t state, state_nxt;
  cls_t   cls;
  logic   legal, dec_imm, is_shift, br_take, ir_load, retire, set_illegal, ctl_valid;
  logic [3:0]      dec_op;
  logic [4:0]      dec_wa;
  logic [5:0]      opcode, funct;
  logic [PC_W-1:0] pc_nxt, pc_inc;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign pc_inc = pc + PC_ONE;

  always_comb begin
    legal    = 1'b1;
    cls      = C_ALU;
    dec_op   = 4'd0;
    dec_imm  = 1'b0;
    dec_wa   = ir[20:16];
    is_shift = 1'b0;
    case (opcode)
      6'd0: begin
        dec_wa = ir[15:11];
        case (funct)
          6'd0:        begin dec_op = 4'd8;  is_shift = 1'b1; end
          6'd2:        begin dec_op = 4'd9;  is_shift = 1'b1; end
          6'd3:        begin dec_op = 4'd10; is_shift = 1'b1; end
          6'd8:        cls = C_JR;
          6'd32, 6'd33: dec_op = 4'd0;
          6'd34, 6'd35: dec_op = 4'd1;
          6'd36:       dec_op = 4'd2;
          6'd37:       dec_op = 4'd3;
          6'd38:       dec_op = 4'd4;
          6'd39:       dec_op = 4'd5;
          6'd42:       dec_op = 4'd6;
          6'd43:       dec_op = 4'd7;
          default:     legal = 1'b0;
        endcase
      end
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7: begin cls = C_BR; dec_op = 4'd1; end
      6'd8, 6'd9: dec_imm = 1'b1;
      6'd10:      begin dec_op = 4'd6;  dec_imm = 1'b1; end
      6'd12:      begin dec_op = 4'd2;  dec_imm = 1'b1; end
      6'd13:      begin dec_op = 4'd3;  dec_imm = 1'b1; end
      6'd14:      begin dec_op = 4'd4;  dec_imm = 1'b1; end
      6'd15:      begin dec_op = 4'd11; dec_imm = 1'b1; end
      6'd35:      begin cls = C_LW; dec_imm = 1'b1; end
      6'd43:      begin cls = C_SW; dec_imm = 1'b1; end
      6'd2:       cls = C_J;
      6'd3:       begin cls = C_JAL; dec_wa = 5'd31; end
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      6'd1:    br_take = rs_data[31];
      6'd4:    br_take = (rs_data == rt_data);
      6'd5:    br_take = (rs_data != rt_data);
      6'd6:    br_take = rs_data[31] || (rs_data == 32'd0);
      6'd7:    br_take = !rs_data[31] && (rs_data != 32'd0);
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_load     = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        ir_load   = 1'b1;
        state_nxt = (imem_data == HALT_WORD) ? S_HALT : S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          set_illegal = 1'b1;
          state_nxt   = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LW, C_SW: state_nxt = S_MEM;
          C_BR: begin
            pc_nxt    = br_take ? ir[PC_W-1:0] : pc_inc;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          C_J: begin
            pc_nxt    = ir[PC_W-1:0];
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          C_JR: begin
            pc_nxt    = rs_data[PC_W-1:0];
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls == C_SW) begin
          pc_nxt    = pc_inc;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        pc_nxt    = (cls == C_JAL) ? ir[PC_W-1:0] : pc_inc;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_load)     ir      <= imem_data;
      if (retire)      retired <= retired + 16'd1;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Decoded controls are only presented while an instruction is in flight.
  assign ctl_valid   = (state == S_DECODE) || (state == S_EXEC) ||
                       (state == S_MEM) || (state == S_WB);
  assign imem_addr   = pc;
  assign rf_ra1      = is_shift ? ir[20:16] : ir[25:21];
  assign rf_ra2      = ir[20:16];
  assign rf_wa       = ctl_valid ? dec_wa : 5'd0;
  assign alu_op      = ctl_valid ? dec_op : 4'd0;
  assign alu_src_imm = ctl_valid && dec_imm;
  assign wb_sel      = !ctl_valid ? 2'd0 : (cls == C_LW) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0;
  assign rf_we       = (state == S_WB) && (dec_wa != 5'd0);
  assign dmem_we     = (state == S_MEM) && (cls == C_SW);
  assign busy        = ctl_valid || (state == S_FETCH);
  assign done        = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: vector table of single instructions plus
// hand sequences, with a scoreboard of expected rf_we/dmem_we pulses.
module tb_mips_multicycle_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] imem_data, rs_data, rt_data;
  logic [9:0]  imem_addr, pc;
  logic [31:0] ir;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we, alu_src_imm, dmem_we, busy, done, illegal;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_op;
  logic [15:0] retired;

  logic [31:0] imem [0:1023];
  assign imem_data = imem[imem_addr];

  mips_multicycle_ctrl #(.PC_W(10), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_data(imem_data),
    .rs_data(rs_data), .rt_data(rt_data), .imem_addr(imem_addr), .pc(pc),
    .ir(ir), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .dmem_we(dmem_we), .busy(busy), .done(done), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       kind;   // 0 = rf_we pulse, 1 = dmem_we pulse
    logic [4:0] wa;
    logic [1:0] wb;
    int         cyc;
  } ev_t;

  ev_t sbq[$];

  // cycle index since the start edge: 1 = FETCH of the first instruction
  int cyc = 0;
  always @(posedge clk) begin
    if (start) cyc = 1;
    else       cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rf_we && dmem_we) check("we_overlap", 32'd1, 32'd0);
      if (rf_we || dmem_we) begin
        if (sbq.size() == 0) begin
          check("unexpected_we", {30'd0, rf_we, dmem_we}, 32'd0);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          check("we_kind", {31'd0, dmem_we}, {31'd0, e.kind});
          check("we_cycle", cyc, e.cyc);
          if (!e.kind) begin
            check("we_rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
            check("we_wb_sel", {30'd0, wb_sel}, {30'd0, e.wb});
          end
        end
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = HALT;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push_ev(input logic kind, input logic [4:0] wa, input logic [1:0] wb, input int c);
    ev_t e;
    e.kind = kind; e.wa = wa; e.wb = wb; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic wait_retired(input int n, input int bound, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (retired == 16'(n)) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_timeout"}, {16'd0, retired}, n);
  endtask

  task automatic wait_done(input int bound, input string name, output int k_done);
    k_done = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (done) begin k_done = k; break; end
    end
    if (k_done < 0) check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] instr, rs, rt;
    int          lat;
    logic [9:0]  npc;
    logic [3:0]  op;
    logic        imm;
    logic [4:0]  ra1;
    logic        we;
    logic [4:0]  wa;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input int lat, input logic [9:0] npc, input logic [3:0] op,
                         input logic imm, input logic [4:0] ra1, input logic we, input logic [4:0] wa);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.lat = lat; v.npc = npc;
    v.op = op; v.imm = imm; v.ra1 = ra1; v.we = we; v.wa = wa;
    vecs.push_back(v);
  endtask

  initial begin
    int kd;
    reset = 1'b1; start = 1'b0; rs_data = '0; rt_data = '0;
    clear_imem();

    //          instr          rs            rt    lat npc     op    imm ra1 we wa
    add_vec(32'h2005_0007, 32'd0,        32'd0, 4, 10'h001, 4'd0,  1, 0, 1, 5);  // addi $5,$0,7
    add_vec(32'h0022_1820, 32'd0,        32'd0, 4, 10'h001, 4'd0,  0, 1, 1, 3);  // add $3,$1,$2
    add_vec(32'h0022_2022, 32'd0,        32'd0, 4, 10'h001, 4'd1,  0, 1, 1, 4);  // sub $4,$1,$2
    add_vec(32'h0002_30C0, 32'd0,        32'd0, 4, 10'h001, 4'd8,  0, 2, 1, 6);  // sll $6,$2,3
    add_vec(32'h0022_382B, 32'd0,        32'd0, 4, 10'h001, 4'd7,  0, 1, 1, 7);  // sltu $7,$1,$2
    add_vec(32'h3429_00FF, 32'd0,        32'd0, 4, 10'h001, 4'd3,  1, 1, 1, 9);  // ori $9,$1,0xFF
    add_vec(32'h3C0A_1234, 32'd0,        32'd0, 4, 10'h001, 4'd11, 1, 0, 1, 10); // lui $10,0x1234
    add_vec(32'h2020_0005, 32'd0,        32'd0, 4, 10'h001, 4'd0,  1, 1, 0, 0);  // addi $0,$1,5
    add_vec(32'h1022_0020, 32'd9,        32'd9, 3, 10'h020, 4'd1,  0, 1, 0, 0);  // beq taken
    add_vec(32'h1022_0020, 32'd9,        32'd8, 3, 10'h001, 4'd1,  0, 1, 0, 0);  // beq not taken
    add_vec(32'h1422_0030, 32'd9,        32'd8, 3, 10'h030, 4'd1,  0, 1, 0, 0);  // bne taken
    add_vec(32'h1820_0011, 32'd0,        32'd0, 3, 10'h011, 4'd1,  0, 1, 0, 0);  // blez rs=0
    add_vec(32'h1C20_0012, 32'd0,        32'd0, 3, 10'h001, 4'd1,  0, 1, 0, 0);  // bgtz rs=0
    add_vec(32'h1C20_0012, 32'd5,        32'd0, 3, 10'h012, 4'd1,  0, 1, 0, 0);  // bgtz rs=5
    add_vec(32'h0420_0013, 32'h8000_0000, 32'd0, 3, 10'h013, 4'd1, 0, 1, 0, 0);  // bltz negative
    add_vec(32'h0020_0008, 32'h0000_0155, 32'd0, 3, 10'h155, 4'd0, 0, 1, 0, 0);  // jr $1
    add_vec(32'h0800_02AA, 32'd0,        32'd0, 3, 10'h2AA, 4'd0,  0, 0, 0, 0);  // j 0x2AA

    do_reset();
    check("rst_pc", {22'd0, pc}, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_flags", {26'd0, busy, done, illegal, rf_we, dmem_we, alu_src_imm}, 32'd0);
    check("rst_ctl", {21'd0, rf_wa, wb_sel, alu_op}, 32'd0);

    foreach (vecs[i]) begin
      int got;
      do_reset();
      clear_imem();
      imem[0] = vecs[i].instr;
      rs_data = vecs[i].rs;
      rt_data = vecs[i].rt;
      if (vecs[i].we) push_ev(1'b0, vecs[i].wa, 2'd0, vecs[i].lat);
      pulse_start();
      got = -1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 2) begin
          check($sformatf("v%0d_alu_op", i), {28'd0, alu_op}, {28'd0, vecs[i].op});
          check($sformatf("v%0d_imm", i), {31'd0, alu_src_imm}, {31'd0, vecs[i].imm});
          check($sformatf("v%0d_ra1", i), {27'd0, rf_ra1}, {27'd0, vecs[i].ra1});
        end
        if (retired == 16'd1) begin got = k - 1; break; end
      end
      check($sformatf("v%0d_latency", i), got, vecs[i].lat);
      check($sformatf("v%0d_pc", i), {22'd0, pc}, {22'd0, vecs[i].npc});
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_halted", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_sb_empty", i), sbq.size(), 32'd0);
    end

    // reset during WB of add $3,$1,$2 drops the write
    do_reset();
    clear_imem();
    imem[0] = 32'h0022_1820;
    push_ev(1'b0, 5'd3, 2'd0, 4);
    pulse_start();
    kd = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rf_we) begin kd = k; break; end
    end
    check("rstwb_we_cycle", kd, 32'd4);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstwb_rf_we", {31'd0, rf_we}, 32'd0);
    check("rstwb_pc", {22'd0, pc}, 32'd0);
    check("rstwb_retired", {16'd0, retired}, 32'd0);
    check("rstwb_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // sw then lw
    do_reset();
    clear_imem();
    imem[0] = 32'hAC22_0004;  // sw $2,4($1)
    imem[1] = 32'h8C28_0008;  // lw $8,8($1)
    push_ev(1'b1, 5'd0, 2'd0, 4);
    push_ev(1'b0, 5'd8, 2'd1, 9);
    pulse_start();
    wait_retired(2, 30, "swlw");
    check("swlw_retired", {16'd0, retired}, 32'd2);
    check("swlw_pc", {22'd0, pc}, 32'd2);
    repeat (2) @(negedge clk);
    check("swlw_done", {31'd0, done}, 32'd1);
    check("swlw_sb_empty", sbq.size(), 32'd0);

    // jal at the top of the address space
    do_reset();
    clear_imem();
    imem[0]     = 32'h0800_03FF;  // j 0x3FF
    imem[10'h3FF] = 32'h0C00_0040;  // jal 0x40
    push_ev(1'b0, 5'd31, 2'd2, 7);
    pulse_start();
    wait_retired(2, 30, "jal");
    check("jal_pc", {22'd0, pc}, 32'h40);
    check("jal_sb_empty", sbq.size(), 32'd0);

    // pc+1 wraps to 0
    do_reset();
    clear_imem();
    imem[0]       = 32'h0800_03FF;
    imem[10'h3FF] = 32'h0022_1820;
    push_ev(1'b0, 5'd3, 2'd0, 7);
    pulse_start();
    wait_retired(2, 30, "wrap");
    check("wrap_pc", {22'd0, pc}, 32'd0);
    check("wrap_sb_empty", sbq.size(), 32'd0);

    // unsupported opcode halts with illegal set; start ignored afterwards
    do_reset();
    clear_imem();
    imem[0] = {6'd50, 26'd0};
    pulse_start();
    wait_done(10, "illop", kd);
    check("illop_done_cycle", kd, 32'd3);
    check("illop_illegal", {31'd0, illegal}, 32'd1);
    check("illop_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    repeat (4) @(negedge clk);
    check("illop_still_done", {31'd0, done}, 32'd1);
    check("illop_pc", {22'd0, pc}, 32'd0);
    check("illop_retired", {16'd0, retired}, 32'd0);

    // unsupported funct
    do_reset();
    clear_imem();
    imem[0] = 32'h0022_1821;
    push_ev(1'b0, 5'd3, 2'd0, 4);
    sbq.delete();
    imem[0] = 32'h0022_183F;  // funct 63
    pulse_start();
    wait_done(10, "illfn", kd);
    check("illfn_illegal", {31'd0, illegal}, 32'd1);

    // HALT_WORD at pc 0
    do_reset();
    clear_imem();
    pulse_start();
    wait_done(10, "hw", kd);
    check("hw_done_cycle", kd, 32'd2);
    check("hw_illegal", {31'd0, illegal}, 32'd0);
    check("hw_retired", {16'd0, retired}, 32'd0);
    check("hw_ir", ir, HALT);
    check("final_sb_empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the Mini-MIPS integer datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It owns the PC and IR and drives register-file read/write addresses and enables, ALU operation select, writeback mux select, and data-memory write enable. The ALU, register file and memories sit outside this block; it only sees operand values (for branches) and instruction words.

Parameters:
PC_W, 10, PC / instruction-memory address width (word addressed)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts execution

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; in IDLE, begins execution at PC=0
imem_data  in  32  instruction word at imem_addr; combinational read, valid same cycle
rs_data  in  32  register-file port-1 data for rf_ra1; combinational
rt_data  in  32  register-file port-2 data for rf_ra2; combinational
imem_addr  out  PC_W  instruction-memory read address, equals pc
pc  out  PC_W  current program counter
ir  out  32  latched instruction register
rf_ra1  out  5  register read address 1, equals ir[25:21] except shifts, where it is ir[20:16]
rf_ra2  out  5  register read address 2, equals ir[20:16]
rf_wa  out  5  register write address
rf_we  out  1  register write enable, one-cycle pulse
wb_sel  out  2  writeback source: 0=ALU, 1=data memory, 2=pc+1
alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI
alu_src_imm  out  1  ALU operand B: 1=zero-extended ir[15:0], 0=rt_data
dmem_we  out  1  data-memory write enable, one-cycle pulse
busy  out  1  high from FETCH through HALT entry
done  out  1  high while in HALT
illegal  out  1  sticky; set when HALT was caused by an unsupported opcode or funct
retired  out  16  count of completed instructions, wraps at 16'hFFFF

Behaviour:
- Reset: state=IDLE; pc, ir, rf_wa, alu_op, wb_sel, retired = 0; rf_we, dmem_we, alu_src_imm, busy, done, illegal = 0. Reset overrides every state, including mid-instruction; any pending write is dropped.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE -> FETCH on start. start is ignored in every other state.
- FETCH: ir <= imem_data.
  - If imem_data == HALT_WORD, go to HALT.
  - Otherwise go to DECODE.
- DECODE:
  - Register operands and alu_op/alu_src_imm are valid from this state through WB.
  - Unsupported opcode or funct: illegal<=1, go to HALT.
  - Otherwise go to EXEC.
- Supported R-type (opcode 0), by funct: sll 0, srl 2, sra 3, jr 8, add 32, addu 33, sub 34, subu 35, and 36, or 37, xor 38, nor 39, slt 42, sltu 43.
- Supported I-type, by opcode: bltz 1, beq 4, bne 5, blez 6, bgtz 7, addi 8, addiu 9, slti 10, andi 12, ori 13, xori 14, lui 15, lw 35, sw 43.
- Supported J-type, by opcode: j 2, jal 3.
- EXEC:
  - ALU ops go to WB.
  - lw and sw go to MEM.
  - Branches: pc <= ir[PC_W-1:0] (absolute) when the condition holds, else pc+1. Then retire and go to FETCH.
  - Branch conditions: beq rs==rt; bne rs!=rt; bltz rs[31]; blez rs[31] or rs==0; bgtz !rs[31] and rs!=0.
  - j: pc <= ir[PC_W-1:0], retire, go to FETCH.
  - jr: pc <= rs_data[PC_W-1:0], retire, go to FETCH.
  - jal: go to WB.
- MEM:
  - sw: dmem_we=1 for this cycle only, pc<=pc+1, retire, go to FETCH.
  - lw: go to WB.
- WB:
  - rf_we=1 for this cycle only, except rf_we is forced to 0 when rf_wa==0.
  - rf_wa is rd for R-type, rt for I-type, and 31 for jal.
  - wb_sel is 1 for lw, 2 for jal, else 0.
  - jal: pc <= ir[PC_W-1:0]. All others: pc <= pc+1.
  - Retire, go to FETCH.
- HALT: terminal; done=1, busy=0. Only reset exits.
- Arithmetic and edge cases:
  - pc+1 wraps from 2^PC_W-1 to 0.
  - jal writes the pre-jump pc+1, zero-extended to 32 bits.
  - retired increments by exactly 1 on each instruction's final cycle.
- Latency in cycles:
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - lw: 5.
  - sw: 4.
  - branches, j, jr: 3.
  - jal: 4.
- rf_we and dmem_we are never high in the same cycle.

Test Plan:
- Reset mid-WB of `add $3,$1,$2` → rf_we=0 on the next cycle; state=IDLE, pc=0, retired=0.
- `addi $5,$0,7` at pc 0 → rf_we high in cycle 4 only, with rf_wa=5, alu_op=0, alu_src_imm=1; pc=1; retired=1.
- `sw` then `lw` → dmem_we high in the sw MEM cycle only; lw raises rf_we in its 5th cycle with wb_sel=1; retired=2.
- `beq` with rs_data=rt_data=9 and target 0x20 → pc=0x20 after 3 cycles. With rt_data=8 → pc=old+1.
- `jal 0x40` at pc 0x3FF → rf_wa=31, wb_sel=2, pc=0x40. PC wrap check: an `add` at pc 0x3FF leaves pc=0.
- Opcode 6'd50 → illegal=1 and done=1, no rf_we/dmem_we ever asserted, start ignored. HALT_WORD at pc 0 → done=1, illegal=0, retired=0.
